// File: rtl/rand_pos_gen_pkg.sv
// Shared definitions for the random on-grid coordinate generator:
// FSM state encoding and the default grid geometry.
package rand_pos_gen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_X_BITS  = 6;
    localparam int DEF_Y_BITS  = 5;
    localparam int DEF_X_LIMIT = 40;
    localparam int DEF_Y_LIMIT = 30;

endpackage

// File: rtl/rand_pos_gen_lfsr_core.sv
// Galois right-shift LFSR with seed load; an all-zero state (or a zero
// seed) is replaced by SEED so the register can never lock up.
module lfsr_core #(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] TAPS  = 16'hB400,
    parameter logic [WIDTH-1:0] SEED  = 16'hACE1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             step,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] state
);

    logic [WIDTH-1:0] stepped;

    assign stepped = (state >> 1) ^ (state[0] ? TAPS : '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SEED;
        end else if (load) begin
            state <= (load_val == '0) ? SEED : load_val;
        end else if (state == '0) begin
            state <= SEED;
        end else if (step) begin
            state <= stepped;
        end
    end

endmodule

// File: rtl/rand_pos_gen.sv
// Draws in-range (x, y) pairs from an LFSR by rejection sampling, with a
// single-subtraction fold after MAX_TRIES rejected draws.
//
//   state | meaning
//   IDLE  | waiting for req
//   DRAW  | sampling LFSR each cycle until in range or out of tries
//   DONE  | valid strobe, result registered
module rand_pos_gen
    import rand_pos_gen_pkg::*;
#(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] TAPS      = 16'hB400,
    parameter logic [WIDTH-1:0] SEED      = 16'hACE1,
    parameter int               X_BITS    = DEF_X_BITS,
    parameter int               Y_BITS    = DEF_Y_BITS,
    parameter int               X_LIMIT   = DEF_X_LIMIT,
    parameter int               Y_LIMIT   = DEF_Y_LIMIT,
    parameter int               MAX_TRIES = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic              seed_load,
    input  logic [WIDTH-1:0]  seed_in,
    input  logic              req,
    output logic              busy,
    output logic              valid,
    output logic [X_BITS-1:0] x_out,
    output logic [Y_BITS-1:0] y_out,
    output logic              fallback,
    output logic [WIDTH-1:0]  lfsr_q
);

    localparam int TW = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
    localparam logic [TW-1:0]     LAST_TRY = TW'(MAX_TRIES - 1);
    // One extra bit so a limit equal to 2^BITS still compares correctly.
    localparam logic [X_BITS:0]   X_CMP    = (X_BITS + 1)'(X_LIMIT);
    localparam logic [Y_BITS:0]   Y_CMP    = (Y_BITS + 1)'(Y_LIMIT);
    localparam logic [X_BITS-1:0] X_SUB    = X_BITS'(X_LIMIT);
    localparam logic [Y_BITS-1:0] Y_SUB    = Y_BITS'(Y_LIMIT);

    state_t            state_q, state_d;
    logic [TW-1:0]     tries_q, tries_d;
    logic [WIDTH-1:0]  lfsr_state;
    logic [X_BITS-1:0] xs, x_d;
    logic [Y_BITS-1:0] ys, y_d;
    logic              x_in, y_in, take, fb_d;

    lfsr_core #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS),
        .SEED  (SEED)
    ) u_lfsr (
        .clk      (clk),
        .rst_n    (rst_n),
        .step     (run || (state_q == DRAW)),
        .load     (seed_load),
        .load_val (seed_in),
        .state    (lfsr_state)
    );

    assign xs   = lfsr_state[X_BITS-1:0];
    assign ys   = lfsr_state[X_BITS+Y_BITS-1:X_BITS];
    assign x_in = {1'b0, xs} < X_CMP;
    assign y_in = {1'b0, ys} < Y_CMP;

    always_comb begin
        state_d = state_q;
        tries_d = tries_q;
        take    = 1'b0;
        fb_d    = 1'b0;
        x_d     = xs;
        y_d     = ys;
        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = DRAW;
                    tries_d = '0;
                end
            end
            DRAW: begin
                if (x_in && y_in) begin
                    take    = 1'b1;
                    state_d = DONE;
                end else if (tries_q == LAST_TRY) begin
                    take    = 1'b1;
                    fb_d    = 1'b1;
                    if (!x_in) x_d = xs - X_SUB;
                    if (!y_in) y_d = ys - Y_SUB;
                    state_d = DONE;
                end else begin
                    tries_d = tries_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            tries_q  <= '0;
            x_out    <= '0;
            y_out    <= '0;
            fallback <= 1'b0;
        end else begin
            state_q <= state_d;
            tries_q <= tries_d;
            if (take) begin
                x_out    <= x_d;
                y_out    <= y_d;
                fallback <= fb_d;
            end
        end
    end

    assign busy   = (state_q == DRAW);
    assign valid  = (state_q == DONE);
    assign lfsr_q = lfsr_state;

endmodule

// File: tb/tb_rand_pos_gen.sv
// Directed bench for rand_pos_gen: a default instance and a MAX_TRIES=1
// instance share stimulus so the fold path is reachable in one draw.
module tb_rand_pos_gen;

    logic        clk = 1'b0;
    logic        rst_n, run, seed_load, req;
    logic [15:0] seed_in;

    logic        busy0, valid0, fb0;
    logic [5:0]  x0;
    logic [4:0]  y0;
    logic [15:0] q0;
    logic        busy1, valid1, fb1;
    logic [5:0]  x1;
    logic [4:0]  y1;
    logic [15:0] q1;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    rand_pos_gen dut0 (
        .clk(clk), .rst_n(rst_n), .run(run), .seed_load(seed_load),
        .seed_in(seed_in), .req(req), .busy(busy0), .valid(valid0),
        .x_out(x0), .y_out(y0), .fallback(fb0), .lfsr_q(q0)
    );

    rand_pos_gen #(.MAX_TRIES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .run(run), .seed_load(seed_load),
        .seed_in(seed_in), .req(req), .busy(busy1), .valid(valid1),
        .x_out(x1), .y_out(y1), .fallback(fb1), .lfsr_q(q1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Load a seed, issue one request (held over the first DRAW cycle, where it
    // must be ignored) and check both instances' results and timing.
    task automatic do_req(input string tag, input logic [15:0] seed,
                          input int ex0, input int ey0, input int efb0, input int lat0,
                          input int eq0,
                          input int ex1, input int ey1, input int efb1, input int lat1);
        int got_lat0 = 0, got_lat1 = 0, nv0 = 0, nv1 = 0, nb0 = 0;
        logic [5:0] cx0 = '0, cx1 = '0;
        logic [4:0] cy0 = '0, cy1 = '0;
        logic       cf0 = 1'b0, cf1 = 1'b0;
        @(negedge clk);
        seed_in   = seed;
        seed_load = 1'b1;
        @(negedge clk);
        seed_load = 1'b0;
        check({tag, "_seed"}, 32'(q0), 32'(seed));
        req = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c == 2) req = 1'b0;
            if (busy0) nb0++;
            if (valid0) begin
                nv0++;
                if (got_lat0 == 0) begin
                    got_lat0 = c; cx0 = x0; cy0 = y0; cf0 = fb0;
                end
            end
            if (valid1) begin
                nv1++;
                if (got_lat1 == 0) begin
                    got_lat1 = c; cx1 = x1; cy1 = y1; cf1 = fb1;
                end
            end
        end
        check({tag, "_lat0"},   32'(got_lat0), 32'(lat0));
        check({tag, "_nvalid0"}, 32'(nv0), 32'd1);
        check({tag, "_nbusy0"}, 32'(nb0), 32'(lat0 - 1));
        check({tag, "_x0"},     32'(cx0), 32'(ex0));
        check({tag, "_y0"},     32'(cy0), 32'(ey0));
        check({tag, "_fb0"},    32'(cf0), 32'(efb0));
        check({tag, "_xhold0"}, 32'(x0), 32'(ex0));
        check({tag, "_yhold0"}, 32'(y0), 32'(ey0));
        check({tag, "_q0"},     32'(q0), 32'(eq0));
        check({tag, "_lat1"},   32'(got_lat1), 32'(lat1));
        check({tag, "_nvalid1"}, 32'(nv1), 32'd1);
        check({tag, "_x1"},     32'(cx1), 32'(ex1));
        check({tag, "_y1"},     32'(cy1), 32'(ey1));
        check({tag, "_fb1"},    32'(cf1), 32'(efb1));
    endtask

    initial begin
        int nvalid;
        bit seen0, seen1;
        rst_n = 1'b0; run = 1'b0; seed_load = 1'b0; seed_in = '0; req = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy0), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_q",     32'(q0), 32'hACE1);
        check("rst_busy0", 32'(busy0), 32'd0);
        check("rst_valid", 32'(valid0), 32'd0);
        check("rst_x",     32'(x0), 32'd0);
        check("rst_y",     32'(y0), 32'd0);
        check("rst_fb",    32'(fb0), 32'd0);

        // Seed 1 then one free-run step: pure tap mask.
        seed_in = 16'h0001; seed_load = 1'b1;
        @(negedge clk);
        seed_load = 1'b0;
        check("seed1", 32'(q0), 32'h0001);
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        check("step1", 32'(q0), 32'hB400);
        @(negedge clk);
        check("hold", 32'(q0), 32'hB400);

        seed_in = 16'h0000; seed_load = 1'b1;
        @(negedge clk);
        seed_load = 1'b0;
        check("seed0", 32'(q0), 32'hACE1);

        //      tag   seed      x0 y0 f0 lat q0         x1 y1 f1 lat1
        do_req("inr",  16'h0145,  5, 5, 0, 2, 32'hB4A2,  5, 5, 0, 2);
        do_req("xout", 16'h0030, 24, 0, 0, 3, 32'h000C,  8, 0, 1, 2);
        do_req("xmax", 16'h003F, 31,16, 0, 3, 32'hEE0F, 23, 0, 1, 2);
        do_req("yout", 16'h0780,  0,15, 0, 3, 32'h01E0,  0, 0, 1, 2);
        do_req("fold", 16'h07FF, 23, 6, 1, 9, 32'hD8DF, 23, 1, 1, 2);

        // Reset in the middle of a long draw.
        @(negedge clk);
        seed_in = 16'h07FF; seed_load = 1'b1;
        @(negedge clk);
        seed_load = 1'b0; req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        check("mid_busy", 32'(busy0), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy0), 32'd0);
        check("arst_q",    32'(q0), 32'hACE1);
        @(negedge clk);
        rst_n = 1'b1;
        nvalid = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (valid0 || valid1) nvalid++;
        end
        check("arst_novalid", 32'(nvalid), 32'd0);

        for (int i = 0; i < 1000; i++) begin
            seed_load = ($urandom_range(0, 3) == 0);
            seed_in   = 16'($urandom);
            run       = 1'($urandom_range(0, 1));
            req       = 1'b1;
            @(negedge clk);
            seed_load = 1'b0;
            req = 1'b0;
            seen0 = 1'b0; seen1 = 1'b0;
            for (int c = 0; c < 12 && !(seen0 && seen1); c++) begin
                @(negedge clk);
                if (valid0 && !seen0) begin
                    seen0 = 1'b1;
                    check("rnd_x0", 32'(x0 < 6'd40), 32'd1);
                    check("rnd_y0", 32'(y0 < 5'd30), 32'd1);
                end
                if (valid1 && !seen1) begin
                    seen1 = 1'b1;
                    check("rnd_x1", 32'(x1 < 6'd40), 32'd1);
                    check("rnd_y1", 32'(y1 < 5'd30), 32'd1);
                end
            end
            check("rnd_done", 32'({seen0, seen1}), 32'd3);
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rand_pos_gen.md
RAND_POS_GEN -- requirements
Module: rand_pos_gen

Interface
REQ-001 Parameters SHALL be: WIDTH, 16, LFSR width (>= X_BITS+Y_BITS).
REQ-002 TAPS, 16'hB400, Galois feedback mask (WIDTH bits).
REQ-003 SEED, 16'hACE1, reset/fallback seed (non-zero).
REQ-004 X_BITS, 6, X coordinate width; Y_BITS, 5, Y coordinate width.
REQ-005 X_LIMIT, 40, X range [0,X_LIMIT); Y_LIMIT, 30, Y range [0,Y_LIMIT); constraint: X_LIMIT <= 2^X_BITS < 2*X_LIMIT, same for Y.
REQ-006 MAX_TRIES, 8, draws before fallback (>= 1).
REQ-007 Ports SHALL be: clk  in  1  single clock, rising edge.
REQ-008 rst_n  in  1  reset, asynchronous, active-low.
REQ-009 run  in  1  free-run enable; LFSR steps every cycle while high.
REQ-010 seed_load  in  1  load seed_in into LFSR.
REQ-011 seed_in  in  WIDTH  seed value.
REQ-012 req  in  1  request one in-range coordinate pair.
REQ-013 busy  out  1  high from the cycle after an accepted req until valid.
REQ-014 valid  out  1  one-cycle result strobe.
REQ-015 x_out  out  X_BITS  X coordinate; y_out  out  Y_BITS  Y coordinate; held until next valid.
REQ-016 fallback  out  1  high with valid when the result came from the fallback path.
REQ-017 lfsr_q  out  WIDTH  current LFSR state.

Function
REQ-018 LFSR step SHALL be Galois right shift: next = (state >> 1) XOR (state[0] ? TAPS : 0).
REQ-019 LFSR SHALL step when run=1 or FSM is in DRAW; otherwise hold.
REQ-020 seed_load SHALL take priority over stepping; seed_in=0 loads SEED instead (no lockup).
REQ-021 If LFSR state is ever 0, next state SHALL be SEED.
REQ-022 FSM states SHALL be IDLE, DRAW, DONE.
REQ-023 IDLE: req=1 -> DRAW, try counter cleared; req in DRAW/DONE SHALL be ignored (not queued).
REQ-024 DRAW samples current state before stepping: xs = state[X_BITS-1:0], ys = state[X_BITS+Y_BITS-1:X_BITS].
REQ-025 DRAW: xs<X_LIMIT and ys<Y_LIMIT -> register xs/ys, fallback=0, go DONE.
REQ-026 DRAW: out of range and tries<MAX_TRIES-1 -> tries+1, stay DRAW.
REQ-027 DRAW: out of range on try MAX_TRIES-1 -> each out-of-range coordinate minus its LIMIT (single subtraction), fallback=1, go DONE.
REQ-028 DONE: valid=1 for exactly one cycle, then IDLE; latency req->valid = 2..MAX_TRIES+1 cycles.
REQ-029 seed_load during DRAW SHALL reload LFSR; FSM continues drawing from the new state next cycle.
REQ-030 busy SHALL be high in DRAW, low in IDLE and DONE.

Reset
REQ-031 rst_n low SHALL asynchronously set LFSR=SEED, FSM=IDLE, tries=0, valid=0, busy=0, fallback=0, x_out=0, y_out=0.
REQ-032 Reset mid-request SHALL abort it; no valid follows release.

Structure
REQ-033 Shared package SHALL hold the FSM state enum and default grid constants (X_LIMIT, Y_LIMIT, X_BITS, Y_BITS).
REQ-034 LFSR SHALL be a sub-module lfsr_core (WIDTH, TAPS, SEED; step, load, load_val, state).

Verification
REQ-035 Reset release, run=0 -> lfsr_q=16'hACE1, busy=0, valid=0, x_out=0, y_out=0.
REQ-036 run=0, seed_load seed_in=16'h0001, then run=1 one cycle -> lfsr_q=16'hB400.
REQ-037 seed_load seed_in=0 -> lfsr_q=16'hACE1.
REQ-038 run=0, seed 16'h0145 (xs=5, ys=5), req -> busy one cycle, valid 2 cycles after req, x_out=5, y_out=5, fallback=0.
REQ-039 MAX_TRIES=1, run=0, seed 16'h003F (xs=63, ys=0), req -> x_out=23, y_out=0, fallback=1.
REQ-040 rst_n low while busy -> busy=0 immediately, no valid afterwards; 1000 random requests -> every x_out<40, y_out<30.
